// File: rtl/ofmap_serializer.sv
`default_nettype none
// ============================================================================
// Module   : ofmap_serializer
// Purpose  : Buffers full systolic-array output vectors (2 entries) and emits
//            them one accumulator word per transfer, lane 0 first, with a
//            per-tile vector counter that pulses tile_done on tile boundaries.
// Revision : 1.0 - initial release
// ============================================================================
module ofmap_serializer #(
  parameter int OFMAP_WIDTH      = 32,
  parameter int ARRAY_WIDTH      = 3,
  parameter int VECTORS_PER_TILE = 12
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [OFMAP_WIDTH*ARRAY_WIDTH-1:0] vec_dat,
  input  logic                              vec_vld,
  output logic                              vec_rdy,
  output logic [OFMAP_WIDTH-1:0]            ofmap_dat,
  output logic                              ofmap_vld,
  input  logic                              ofmap_rdy,
  output logic                              tile_done,
  output logic                              busy
);

  localparam int VW = OFMAP_WIDTH * ARRAY_WIDTH;
  localparam int LW = (ARRAY_WIDTH > 1) ? $clog2(ARRAY_WIDTH) : 1;
  localparam int TW = (VECTORS_PER_TILE > 1) ? $clog2(VECTORS_PER_TILE) : 1;
  localparam logic [LW-1:0] C_LAST_LANE = LW'(ARRAY_WIDTH - 1);
  localparam logic [TW-1:0] C_LAST_VEC  = TW'(VECTORS_PER_TILE - 1);

  logic [VW-1:0] r_mem [2];
  logic          r_wr_ptr;
  logic          r_rd_ptr;
  logic [1:0]    r_count;
  logic [LW-1:0] r_lane;
  logic [TW-1:0] r_vec_cnt;
  logic          r_tile_done;

  logic          w_push;
  logic          w_xfer;
  logic          w_pop;
  logic          w_lane_last;
  logic [VW-1:0] w_head;

  // Ready is a function of the registered occupancy only; a pop in the same
  // cycle never opens a slot for a push when both entries are taken.
  assign vec_rdy     = !rst && (r_count != 2'd2);
  assign ofmap_vld   = (r_count != 2'd0);
  assign busy        = (r_count != 2'd0);
  assign tile_done   = r_tile_done;

  assign w_push      = vec_vld && vec_rdy;
  assign w_xfer      = ofmap_vld && ofmap_rdy;
  assign w_lane_last = (r_lane == C_LAST_LANE);
  assign w_pop       = w_xfer && w_lane_last;
  assign w_head      = r_mem[r_rd_ptr];

  generate
    if (ARRAY_WIDTH > 1) begin : g_multi_lane
      logic [ARRAY_WIDTH-1:0][OFMAP_WIDTH-1:0] w_lanes;
      assign w_lanes   = w_head;
      assign ofmap_dat = w_lanes[r_lane];
    end else begin : g_single_lane
      assign ofmap_dat = w_head;
    end
  endgenerate

  // Vector storage: data only, no reset needed since count gates visibility.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= vec_dat;
    end
  end

  // Pointers, occupancy, lane/tile counters and the tile_done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr    <= 1'b0;
      r_rd_ptr    <= 1'b0;
      r_count     <= 2'd0;
      r_lane      <= '0;
      r_vec_cnt   <= '0;
      r_tile_done <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
      if (w_xfer) begin
        r_lane <= w_lane_last ? '0 : r_lane + 1'b1;
      end
      if (w_pop) begin
        r_vec_cnt <= (r_vec_cnt == C_LAST_VEC) ? '0 : r_vec_cnt + 1'b1;
      end
      r_tile_done <= w_pop && (r_vec_cnt == C_LAST_VEC);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ofmap_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_ofmap_serializer
// Purpose  : Self-checking bench for ofmap_serializer: directed table,
//            hand-written corner sequences and a randomized run scored
//            against a word-queue reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ofmap_serializer;

  localparam int W   = 32;
  localparam int AW  = 3;
  localparam int VPT = 12;
  localparam int VW  = W * AW;
  localparam int WPT = AW * VPT;

  logic          clk;
  logic          rst;
  logic [VW-1:0] vec_dat;
  logic          vec_vld;
  logic          vec_rdy;
  logic [W-1:0]  ofmap_dat;
  logic          ofmap_vld;
  logic          ofmap_rdy;
  logic          tile_done;
  logic          busy;

  int total = 0;
  int bad   = 0;

  // Reference model: pending output words in emission order.
  logic [W-1:0] q[$];
  int           xfers   = 0;
  logic         exp_td  = 1'b0;
  int           td_seen = 0;

  logic         s_vld, s_rdy, s_busy, s_td;
  logic [W-1:0] s_dat;

  typedef struct {
    logic          vv;
    logic [VW-1:0] vd;
    logic          rr;
    logic          e_vld;
    logic [W-1:0]  e_dat;
    logic          e_rdy;
    logic          e_busy;
  } vec_t;

  vec_t tbl [15];

  ofmap_serializer #(
    .OFMAP_WIDTH      (W),
    .ARRAY_WIDTH      (AW),
    .VECTORS_PER_TILE (VPT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .vec_dat   (vec_dat),
    .vec_vld   (vec_vld),
    .vec_rdy   (vec_rdy),
    .ofmap_dat (ofmap_dat),
    .ofmap_vld (ofmap_vld),
    .ofmap_rdy (ofmap_rdy),
    .tile_done (tile_done),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, want);
    end
  endtask

  function automatic vec_t mk(input logic vv, input logic [VW-1:0] vd, input logic rr,
                              input logic ev, input logic [W-1:0] ed, input logic er,
                              input logic eb);
    vec_t t;
    t.vv = vv; t.vd = vd; t.rr = rr;
    t.e_vld = ev; t.e_dat = ed; t.e_rdy = er; t.e_busy = eb;
    return t;
  endfunction

  // One clock cycle: drive, sample at negedge, score against the model,
  // advance the model by what the interface should have accepted.
  task automatic cycle(input logic vv, input logic [VW-1:0] vd, input logic rr,
                       output logic acc);
    logic m_vld;
    logic m_rdy;
    vec_vld   = vv;
    vec_dat   = vd;
    ofmap_rdy = rr;
    @(negedge clk);
    s_vld  = ofmap_vld;
    s_dat  = ofmap_dat;
    s_rdy  = vec_rdy;
    s_busy = busy;
    s_td   = tile_done;
    m_vld  = (q.size() != 0);
    m_rdy  = (((q.size() + AW - 1) / AW) < 2);
    chk("ofmap_vld", 32'(s_vld), 32'(m_vld));
    chk("vec_rdy",   32'(s_rdy), 32'(m_rdy));
    chk("busy",      32'(s_busy), 32'(m_vld));
    chk("tile_done", 32'(s_td), 32'(exp_td));
    if (m_vld) chk("ofmap_dat", s_dat, q[0]);
    if (s_td) td_seen++;
    exp_td = 1'b0;
    acc = vv && m_rdy;
    if (m_vld && rr) begin
      void'(q.pop_front());
      xfers++;
      if (xfers % WPT == 0) exp_td = 1'b1;
    end
    if (acc) begin
      for (int i = 0; i < AW; i++) q.push_back(vd[i*W +: W]);
    end
    @(posedge clk);
    #1;
  endtask

  // Asynchronous assert away from the clock edge, release just after an edge.
  task automatic do_reset(input string nm);
    #3;
    rst = 1'b1;
    #1;
    chk({nm, "_vld"},  32'(ofmap_vld), 32'd0);
    chk({nm, "_busy"}, 32'(busy), 32'd0);
    chk({nm, "_rdy"},  32'(vec_rdy), 32'd0);
    chk({nm, "_td"},   32'(tile_done), 32'd0);
    vec_vld   = 1'b0;
    ofmap_rdy = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    q.delete();
    xfers  = 0;
    exp_td = 1'b0;
  endtask

  // Producer/consumer loop; stops once the model has seen `target` transfers.
  task automatic run(input string nm, input int nvec, input bit rnd,
                     input int target, input int budget);
    int            sent = 0;
    int            n    = 0;
    logic          acc;
    logic          vv;
    logic          rr;
    logic [VW-1:0] d;
    while (xfers < target && n < budget) begin
      vv = (sent < nvec) && (rnd ? ($urandom_range(0, 1) == 1) : 1'b1);
      rr = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
      for (int i = 0; i < AW; i++) d[i*W +: W] = rnd ? W'($urandom) : W'(sent * AW + i);
      cycle(vv, d, rr, acc);
      if (acc) sent++;
      n++;
    end
    chk({nm, "_xfers"}, 32'(xfers), 32'(target));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic          acc;
    logic [VW-1:0] v;
    logic [VW-1:0] fv [3];
    int            idx;
    int            c_acc_cyc;

    v = {32'h33, 32'h22, 32'h11};
    tbl[0]  = mk(1'b1, v,  1'b1, 1'b0, 32'h0,  1'b1, 1'b0);
    tbl[1]  = mk(1'b0, '0, 1'b1, 1'b1, 32'h11, 1'b1, 1'b1);
    tbl[2]  = mk(1'b0, '0, 1'b1, 1'b1, 32'h22, 1'b1, 1'b1);
    tbl[3]  = mk(1'b0, '0, 1'b1, 1'b1, 32'h33, 1'b1, 1'b1);
    tbl[4]  = mk(1'b0, '0, 1'b1, 1'b0, 32'h0,  1'b1, 1'b0);
    tbl[5]  = mk(1'b1, v,  1'b0, 1'b0, 32'h0,  1'b1, 1'b0);
    for (int i = 6; i <= 10; i++)
      tbl[i] = mk(1'b0, '0, 1'b0, 1'b1, 32'h11, 1'b1, 1'b1);
    tbl[11] = mk(1'b0, '0, 1'b1, 1'b1, 32'h11, 1'b1, 1'b1);
    tbl[12] = mk(1'b0, '0, 1'b1, 1'b1, 32'h22, 1'b1, 1'b1);
    tbl[13] = mk(1'b0, '0, 1'b1, 1'b1, 32'h33, 1'b1, 1'b1);
    tbl[14] = mk(1'b0, '0, 1'b1, 1'b0, 32'h0,  1'b1, 1'b0);

    rst       = 1'b1;
    vec_vld   = 1'b0;
    vec_dat   = '0;
    ofmap_rdy = 1'b0;

    // Reset state.
    @(posedge clk);
    @(negedge clk);
    chk("reset_vld",  32'(ofmap_vld), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_rdy",  32'(vec_rdy), 32'd0);
    chk("reset_td",   32'(tile_done), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Directed table: single vector drain, then back-pressure hold.
    for (int i = 0; i < 15; i++) begin
      cycle(tbl[i].vv, tbl[i].vd, tbl[i].rr, acc);
      chk($sformatf("tbl%0d_vld", i),  32'(s_vld),  32'(tbl[i].e_vld));
      chk($sformatf("tbl%0d_rdy", i),  32'(s_rdy),  32'(tbl[i].e_rdy));
      chk($sformatf("tbl%0d_busy", i), 32'(s_busy), 32'(tbl[i].e_busy));
      if (tbl[i].e_vld) chk($sformatf("tbl%0d_dat", i), s_dat, tbl[i].e_dat);
    end

    // Fill: three vectors offered with the consumer stalled for 4 cycles.
    fv[0] = {32'hA3, 32'hA2, 32'hA1};
    fv[1] = {32'hB3, 32'hB2, 32'hB1};
    fv[2] = {32'hC3, 32'hC2, 32'hC1};
    idx = 0;
    c_acc_cyc = -1;
    for (int c = 0; c < 14; c++) begin
      cycle(idx < 3, (idx < 3) ? fv[idx] : '0, c >= 4, acc);
      if (acc) begin
        if (idx == 2) c_acc_cyc = c;
        idx++;
      end
    end
    chk("fill_accepted", 32'(idx), 32'd3);
    chk("fill_third_accept_cycle", 32'(c_acc_cyc), 32'd7);
    chk("fill_drained", 32'(q.size()), 32'd0);

    // Streaming: one full tile of sequential data with no bubbles.
    do_reset("rst_stream");
    td_seen = 0;
    run("stream", VPT, 1'b0, WPT, 100);
    cycle(1'b0, '0, 1'b1, acc);
    chk("stream_td_count", 32'(td_seen), 32'd1);

    // Random valid/ready over three tiles.
    do_reset("rst_rand");
    td_seen = 0;
    run("rand", 3 * VPT, 1'b1, 3 * WPT, 3000);
    cycle(1'b0, '0, 1'b1, acc);
    cycle(1'b0, '0, 1'b1, acc);
    chk("rand_td_count", 32'(td_seen), 32'd3);

    // Reset in the middle of a tile, then a fresh full tile.
    do_reset("rst_pre");
    run("partial", VPT, 1'b0, 7, 50);
    chk("partial_busy_before_reset", 32'(busy), 32'd1);
    do_reset("rst_mid");
    td_seen = 0;
    run("fresh", VPT, 1'b0, WPT, 100);
    cycle(1'b0, '0, 1'b1, acc);
    chk("fresh_td_count", 32'(td_seen), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ofmap_serializer.md
# ofmap_serializer

Output-side streaming block for the conv accelerator. Accepts full systolic-array output vectors (one OFMAP_WIDTH accumulator per array column) and emits them one word at a time on the `ofmap_dat`/`ofmap_vld`/`ofmap_rdy` stream toward the output FIFO. It is the transmit counterpart of the ifmap/weights deserializers that pack the 16-bit input streams into array-wide words. A 2-entry vector buffer decouples array drain timing from downstream back-pressure. A per-tile vector counter marks output-tile boundaries.

## Interface
- OFMAP_WIDTH, 32, width of one output word / accumulator
- ARRAY_WIDTH, 3, lanes per vector (systolic array columns); must be ≥1
- VECTORS_PER_TILE, 12, vectors per output tile (OY0*OC0); must be ≥1
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- vec_dat  in  OFMAP_WIDTH*ARRAY_WIDTH  array output vector; lane 0 in LSBs
- vec_vld  in  1  vec_dat valid
- vec_rdy  out  1  buffer can accept a vector
- ofmap_dat  out  OFMAP_WIDTH  current output word
- ofmap_vld  out  1  ofmap_dat valid
- ofmap_rdy  in  1  downstream accepts word
- tile_done  out  1  one-cycle pulse after last word of a tile is accepted
- busy  out  1  buffer non-empty

## Operation
- Storage: 2-entry FIFO of vectors (`wr_ptr`, `rd_ptr` 1 bit each, `count` 0..2), lane counter `lane` (0..ARRAY_WIDTH-1), tile counter `vec_cnt` (0..VECTORS_PER_TILE-1).
- Push: on `vec_vld && vec_rdy`, write vec_dat at wr_ptr, wr_ptr toggles.
- `vec_rdy = !rst && (count != 2)`. It depends only on registered count. A same-cycle pop does not free a slot for a push when full.
- `ofmap_vld = (count != 0)`. `ofmap_dat = head_vector[lane*OFMAP_WIDTH +: OFMAP_WIDTH]`, both driven combinationally from registers only.
- Transfer: `ofmap_vld && ofmap_rdy`. On transfer:
  - lane < ARRAY_WIDTH-1: lane++.
  - lane == ARRAY_WIDTH-1: lane←0, pop (rd_ptr toggles), vec_cnt advances.
- count update: push only +1, pop only −1, push and pop in the same cycle (possible only when count==1) leaves it unchanged.
- vec_cnt: increments on each pop. At VECTORS_PER_TILE-1 with a pop, it wraps to 0 and the registered tile_done is set for exactly the next cycle.
- `busy = (count != 0)`.
- Words leave in lane order 0..ARRAY_WIDTH-1 and vectors in arrival order. Data is passed unmodified, with no truncation or sign handling.
- ARRAY_WIDTH==1: every transfer is also a pop. The lane counter stays 0.

## Timing
- Reset (async assert, sync-safe deassert): count=0, ptrs=0, lane=0, vec_cnt=0, tile_done=0. Therefore ofmap_vld=0, busy=0, vec_rdy=0 while rst is high and 1 after release.
- Latency: a vector pushed at edge N presents lane 0 with ofmap_vld=1 from edge N (same cycle after the edge), when the FIFO was empty.
- Throughput: 1 word/cycle with ofmap_rdy held high. With a sustained producer, one vector is accepted every ARRAY_WIDTH cycles with no bubbles, because the second entry fills while the first drains.
- Back-pressure: while `ofmap_vld && !ofmap_rdy`, ofmap_dat and lane are held stable. A push may still occur if count<2.
- Full: count==2 gives vec_rdy=0, and vec_vld is ignored (no overwrite).
- Empty: ofmap_rdy is ignored with no state change.
- Reset mid-tile discards buffered vectors and the partial tile count. No tile_done is generated for the discarded tile.
- The tile_done pulse is one cycle wide. Consecutive tiles give separate pulses at least ARRAY_WIDTH cycles apart.

## Test plan
- Single vector {lane2=0x33, lane1=0x22, lane0=0x11}, ofmap_rdy=1 → ofmap_dat 0x11, 0x22, 0x33 on 3 consecutive cycles. vld drops after the third word, and busy returns to 0.
- Back-pressure: vector pushed, ofmap_rdy=0 for 5 cycles, then 1 → 0x11 held stable for all 5 cycles, then 3 words in order. No duplication or loss.
- Fill: 3 vectors offered back-to-back with ofmap_rdy=0 → first two accepted, vec_rdy=0 on the third until the first vector fully drains. The third is accepted only after count<2, and all 9 words emerge in order.
- Streaming: 12 vectors (values 0..35), producer always valid, ofmap_rdy=1 → 36 words 0..35 on consecutive cycles. tile_done pulses exactly once, the cycle after word 35.
- Random ofmap_rdy (50%) and vec_vld over 3 tiles → scoreboard match, and exactly 3 tile_done pulses aligned to every 36th transfer.
- Assert rst after 7 words of a tile with 1 vector buffered → outputs return to reset values asynchronously. After release, a fresh 12-vector tile gives tile_done after 36 words, not 29.
